rr_mem_arbiter: RTL



---
 rtl/arb_pkg.sv | 25 ++
 rtl/rr_priority_pick.sv | 33 +++
 rtl/rr_mem_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for rr_mem_arbiter: FSM state encodings, pointer-width helper
// and flattened-bus slice helper. Optional lock feature is enabled by ARB_LOCK_EN.
package arb_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Bits needed to index n requesters; never less than one.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  // Low bit of requester idx's field in a flattened bus of width-bit fields.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin selector: first requesting index at or after ptr, wrapping modulo N.
module rr_priority_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     req_vec,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] g,
  output logic             any
);

  localparam int unsigned SW = PTR_W + 1;

  logic [2*N-1:0] w_shift;
  logic [N-1:0]   w_rot;
  logic [PTR_W-1:0] w_off;
  logic [SW-1:0]  w_sum;

  always_comb begin
    // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate back.
    w_shift = {req_vec, req_vec} >> ptr;
    w_rot   = w_shift[N-1:0];
    w_off   = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (w_rot[i-1]) w_off = PTR_W'(i - 1);
    end
    w_sum = {1'b0, w_off} + {1'b0, ptr};
    if (w_sum >= SW'(N)) w_sum = w_sum - SW'(N);
    g   = w_sum[PTR_W-1:0];
    any = |req_vec;
  end

endmodule

// File: rtl/rr_mem_arbiter.sv
// Round-robin arbiter sharing one single-beat memory port among N requesters.
// Define ARB_LOCK_EN to add lock_vec, which keeps the pointer on a locked owner.
module rr_mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req_vec,
  input  logic [N-1:0]          we_vec,
  input  logic [N*ADDR_W-1:0]   pack_addr_in,
  input  logic [N*DATA_W-1:0]   pack_wdata_in,
  output logic [N-1:0]          grant_vec,
  output logic [N-1:0]          done_vec,
  output logic [DATA_W-1:0]     rdata,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata
`ifdef ARB_LOCK_EN
  ,
  input  logic [N-1:0]          lock_vec
`endif
);

  localparam int unsigned PTR_W = clog2_min1(N);

  logic [1:0]        r_state;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  r_owner;
  logic [N-1:0]      r_grant;
  logic [DATA_W-1:0] r_rdata;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic [PTR_W-1:0]  w_pick;
  logic              w_any;
  logic [PTR_W-1:0]  w_ptr_inc;
  logic [PTR_W-1:0]  w_ptr_next;

  rr_priority_pick #(
    .N     (N),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_vec (req_vec),
    .ptr     (r_ptr),
    .g       (w_pick),
    .any     (w_any)
  );

  always_comb begin
    w_ptr_inc = (r_owner == PTR_W'(N - 1)) ? '0 : r_owner + 1'b1;
`ifdef ARB_LOCK_EN
    w_ptr_next = lock_vec[r_owner] ? r_owner : w_ptr_inc;
`else
    w_ptr_next = w_ptr_inc;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_grant     <= '0;
      r_rdata     <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rdata <= '0;
          if (w_any) begin
            r_owner     <= w_pick;
            r_grant     <= N'(1) << w_pick;
            r_mem_we    <= we_vec[w_pick];
            r_mem_addr  <= pack_addr_in[slice_lo(int'(w_pick), ADDR_W) +: ADDR_W];
            r_mem_wdata <= pack_wdata_in[slice_lo(int'(w_pick), DATA_W) +: DATA_W];
            r_state     <= S_ISSUE;
          end else begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
          end
        end
        S_ISSUE: begin
          if (mem_ready) begin
            if (r_mem_we) begin
              r_state <= S_DONE;
            end else if (mem_rvalid) begin
              r_rdata <= mem_rdata;
              r_state <= S_DONE;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            r_rdata <= mem_rdata;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_grant <= '0;
          r_ptr   <= w_ptr_next;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign grant_vec = r_grant;
  assign done_vec  = (r_state == S_DONE) ? r_grant : '0;
  assign rdata     = r_rdata;
  assign mem_valid = (r_state == S_ISSUE);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
